led_strand_driver: RTL
======================

// Module: led_strand_driver
// PURPOSE
//   Serialises per-LED colours into the single-wire WS2811/WS2812 protocol that drives the LED strand.
//   It requests colours by index over next_led_request and accepts GRB bytes on a valid strobe.
//   The calibration FSM and the normal colour source sit upstream of it. Each 24-bit word is
//   shifted out MSB-first with programmable high/low pulse widths. Every frame ends with a
//   latch (reset) low period.
// PARAMETERS
//   NUM_LEDS          50    LEDs on strand; frame = NUM_LEDS words
//   LED_ADDRESS_WIDTH 6     index width; request bus is LED_ADDRESS_WIDTH+1 bits
//   T0H_CYCLES        40    clk cycles high for a '0' bit (0.40us @100MHz)
//   T0L_CYCLES        85    clk cycles low for a '0' bit
//   T1H_CYCLES        80    clk cycles high for a '1' bit
//   T1L_CYCLES        45    clk cycles low for a '1' bit
//   RESET_CYCLES      6000  clk cycles low for the frame latch (>50us)
// PORTS
//   clk               in   1      system clock
//   rst               in   1      synchronous reset, ACTIVE-LOW
//   green_in          in   8      colour G for the requested LED
//   red_in            in   8      colour R for the requested LED
//   blue_in           in   8      colour B for the requested LED
//   color_valid       in   1      colour bytes valid for current next_led_request
//   next_led_request  out  LED_ADDRESS_WIDTH+1  index of the LED whose colour is wanted
//   strand_out        out  1      serial data line to strand
//   frame_done        out  1      1-cycle pulse at the end of each latch period
// BEHAVIOUR
//   Reset (rst==0 at a clk edge):
//   - next_led_request=0, strand_out=0, frame_done=0, state=WAIT_COLOR.
//   - All counters are cleared. Applies mid-bit or mid-latch: the line drops low on the same edge.
//   States: WAIT_COLOR -> SEND_HIGH -> SEND_LOW -> (SEND_HIGH | WAIT_COLOR | LATCH) -> WAIT_COLOR.
//   WAIT_COLOR:
//   - strand_out=0; next_led_request is held stable.
//   - On color_valid=1, latch shift={green_in,red_in,blue_in} and set bit_idx=23.
//   - Go to SEND_HIGH. strand_out is 1 on the next edge (1-cycle latency from color_valid).
//   - The upstream source may take any number of cycles; the driver waits indefinitely.
//   SEND_HIGH:
//   - strand_out=1 for exactly T1H_CYCLES if shift[bit_idx] else T0H_CYCLES, then go to SEND_LOW.
//   SEND_LOW:
//   - strand_out=0 for T1L_CYCLES or T0L_CYCLES, matching the bit being sent.
//   - If bit_idx>0: decrement bit_idx, go to SEND_HIGH.
//   - If bit_idx==0 and next_led_request<NUM_LEDS-1: increment request on the exit edge, go to WAIT_COLOR.
//   - If bit_idx==0 and next_led_request==NUM_LEDS-1: go to LATCH; request stays at NUM_LEDS-1.
//   LATCH:
//   - strand_out=0 for RESET_CYCLES.
//   - On the final cycle, frame_done=1 for one cycle, next_led_request wraps to 0, go to WAIT_COLOR.
//   Handshake and timing rules:
//   - color_valid is ignored in every state except WAIT_COLOR. No skid buffering.
//   - The colour is captured on the same edge that color_valid is sampled high.
//   - Bit period = high+low cycles exactly; there are no dead cycles between bits.
//   - Between words the line is low for (low cycles + WAIT_COLOR dwell). With a zero-latency
//     source (color_valid=1 in the first WAIT_COLOR cycle), the gap adds exactly one cycle.
//   Widths and parameter rules:
//   - Timing counter width = $clog2(max of all *_CYCLES)+1; it is unsigned and counts down to 1.
//   - Bit index is 5 bits.
//   - Every *_CYCLES value must be >=2; NUM_LEDS must be >=1 and <=2**(LED_ADDRESS_WIDTH+1).
//   - Elaboration fails on violation.
// TESTING
//   1. Hold rst=0, then release -> strand_out=0, next_led_request=0, frame_done=0.
//      With no color_valid the line stays low indefinitely.
//   2. Single word G=0x80,R=0x00,B=0x01 -> first bit high 80 cyc, low 45 cyc.
//      Bits 22..1 are 40/85. Bit 0 is 80/45. Then next_led_request=1.
//   3. NUM_LEDS=3, RESET_CYCLES=20, color_valid tied 1 -> requests 0,1,2.
//      Then 20 low cycles, frame_done pulses once, request returns to 0.
//   4. color_valid pulsed while in SEND_HIGH/SEND_LOW with other data -> transmitted word unchanged;
//      request does not advance early.
//   5. rst=0 asserted mid-bit (strand_out=1) of LED 5 -> next edge strand_out=0 and request=0.
//      After release, the next color_valid restarts at LED 0.
//   6. Upstream delays color_valid 17 cycles per LED -> inter-word low gap = Tlow+17.
//      Bit timing of every word is unaffected.

Source files
------------

// File: rtl/led_strand_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : led_strand_driver_if
// Purpose  : Colour request/response bundle between the colour source and the
//            strand driver (source = master, driver = slave).
// Revision : 1.0 - initial release
// ============================================================================
interface led_strand_driver_if #(
    parameter int LED_ADDRESS_WIDTH = 6
);
    logic [7:0]                 green_in;
    logic [7:0]                 red_in;
    logic [7:0]                 blue_in;
    logic                       color_valid;
    logic [LED_ADDRESS_WIDTH:0] next_led_request;

    modport master (
        output green_in,
        output red_in,
        output blue_in,
        output color_valid,
        input  next_led_request
    );

    modport slave (
        input  green_in,
        input  red_in,
        input  blue_in,
        input  color_valid,
        output next_led_request
    );
endinterface
`default_nettype wire

// File: rtl/led_strand_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_strand_driver
// Purpose  : Serialises GRB words MSB-first onto a WS2811/WS2812 single-wire
//            line, requesting colours by LED index and latching each frame.
// Revision : 1.0 - initial release
// ============================================================================
module led_strand_driver #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = 6,
    parameter int T0H_CYCLES        = 40,
    parameter int T0L_CYCLES        = 85,
    parameter int T1H_CYCLES        = 80,
    parameter int T1L_CYCLES        = 45,
    parameter int RESET_CYCLES      = 6000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    led_strand_driver_if.slave bus,
    output logic               strand_out,
    output logic               frame_done
);

    localparam int c_REQ_W    = LED_ADDRESS_WIDTH + 1;
    localparam int c_MAX_HIGH = (T0H_CYCLES > T1H_CYCLES) ? T0H_CYCLES : T1H_CYCLES;
    localparam int c_MAX_LOW  = (T0L_CYCLES > T1L_CYCLES) ? T0L_CYCLES : T1L_CYCLES;
    localparam int c_MAX_BIT  = (c_MAX_HIGH > c_MAX_LOW) ? c_MAX_HIGH : c_MAX_LOW;
    localparam int c_MAX_CYC  = (c_MAX_BIT > RESET_CYCLES) ? c_MAX_BIT : RESET_CYCLES;
    localparam int c_CNT_W    = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_T0H     = c_CNT_W'(T0H_CYCLES);
    localparam logic [c_CNT_W-1:0] c_T0L     = c_CNT_W'(T0L_CYCLES);
    localparam logic [c_CNT_W-1:0] c_T1H     = c_CNT_W'(T1H_CYCLES);
    localparam logic [c_CNT_W-1:0] c_T1L     = c_CNT_W'(T1L_CYCLES);
    localparam logic [c_CNT_W-1:0] c_RESET   = c_CNT_W'(RESET_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_REQ_W-1:0] c_LAST    = c_REQ_W'(NUM_LEDS - 1);
    localparam logic [c_REQ_W-1:0] c_REQ_ONE = c_REQ_W'(1);
    localparam logic [4:0]         c_MSB_IDX = 5'd23;
    localparam logic [4:0]         c_IDX_ONE = 5'd1;

    localparam logic [1:0] c_WAIT_COLOR = 2'd0;
    localparam logic [1:0] c_SEND_HIGH  = 2'd1;
    localparam logic [1:0] c_SEND_LOW   = 2'd2;
    localparam logic [1:0] c_LATCH      = 2'd3;

    generate
        if (T0H_CYCLES < 2 || T0L_CYCLES < 2 || T1H_CYCLES < 2 || T1L_CYCLES < 2 ||
            RESET_CYCLES < 2 || NUM_LEDS < 1 || NUM_LEDS > (2 ** c_REQ_W)) begin : g_bad_params
            $error("led_strand_driver: illegal parameter combination");
        end
    endgenerate

    logic [1:0]         state_q,   state_d;
    logic [c_CNT_W-1:0] cnt_q,     cnt_d;
    logic [23:0]        shift_q,   shift_d;
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic [c_REQ_W-1:0] req_q,     req_d;
    logic               strand_q,  strand_d;
    logic               frame_done_q, frame_done_d;

    logic w_cur_bit;
    logic w_next_bit;
    logic w_cnt_last;

    assign w_cur_bit  = shift_q[bit_idx_q];
    assign w_next_bit = shift_q[bit_idx_q - c_IDX_ONE];
    assign w_cnt_last = (cnt_q == c_CNT_ONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= c_WAIT_COLOR;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            req_q        <= '0;
            strand_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            req_q        <= req_d;
            strand_q     <= strand_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Each timed state is entered with its full length loaded and leaves when the count reaches 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        req_d     = req_q;
        case (state_q)
            c_WAIT_COLOR: begin
                if (bus.color_valid) begin
                    shift_d   = {bus.green_in, bus.red_in, bus.blue_in};
                    bit_idx_d = c_MSB_IDX;
                    cnt_d     = bus.green_in[7] ? c_T1H : c_T0H;
                    state_d   = c_SEND_HIGH;
                end
            end
            c_SEND_HIGH: begin
                if (w_cnt_last) begin
                    cnt_d   = w_cur_bit ? c_T1L : c_T0L;
                    state_d = c_SEND_LOW;
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            c_SEND_LOW: begin
                if (!w_cnt_last) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end else if (bit_idx_q != 5'd0) begin
                    bit_idx_d = bit_idx_q - c_IDX_ONE;
                    cnt_d     = w_next_bit ? c_T1H : c_T0H;
                    state_d   = c_SEND_HIGH;
                end else if (req_q < c_LAST) begin
                    req_d   = req_q + c_REQ_ONE;
                    state_d = c_WAIT_COLOR;
                end else begin
                    cnt_d   = c_RESET;
                    state_d = c_LATCH;
                end
            end
            c_LATCH: begin
                if (w_cnt_last) begin
                    req_d   = '0;
                    state_d = c_WAIT_COLOR;
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            default: state_d = c_WAIT_COLOR;
        endcase
    end

    // Outputs are decoded from the next state so the line itself comes straight from a flop.
    always_comb begin
        strand_d     = (state_d == c_SEND_HIGH);
        frame_done_d = (state_d == c_LATCH) && (cnt_d == c_CNT_ONE);
    end

    assign strand_out           = strand_q;
    assign frame_done           = frame_done_q;
    assign bus.next_led_request = req_q;

endmodule
`default_nettype wire
